// File: rtl/inst_rom_pkg.sv
// Shared definitions for the instruction ROM/boot-loader slice: bus widths, enables, FSM encodings.
// Checksum logic is built only when INST_ROM_CHECKSUM_EN is defined.
`timescale 1ns/1ps
package inst_rom_pkg;
  localparam int          InstAddrBus    = 32;
  localparam int          InstBus        = 32;
  localparam logic [31:0] ZeroWord       = 32'h0;
  localparam logic        ChipEnable     = 1'b1;
  localparam int          InstMemNumLog2 = 10;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  // Big-endian lane placement: byte index 0 lands in [31:24], index 3 in [7:0].
  function automatic logic [31:0] place_byte(input logic [7:0] b, input logic [1:0] idx);
    return {24'h0, b} << {~idx, 3'b000};
  endfunction
endpackage

// File: rtl/inst_rom_ld_word_asm.sv
// Byte-to-word assembler for the boot loader: 2-bit byte counter, accumulator, zero padding on last.
`timescale 1ns/1ps
module ld_word_asm
  import inst_rom_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        take_i,
  input  logic [7:0]  byte_i,
  input  logic        last_i,
  output logic [31:0] word_o,
  output logic        wr_o
);
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;

  // Unfilled low lanes of acc_q are always zero, so padding comes for free.
  always_comb begin
    word_o = acc_q | place_byte(byte_i, cnt_q);
    wr_o   = take_i & (last_i | (cnt_q == 2'd3));
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    if (clr_i) begin
      cnt_d = 2'd0;
      acc_d = '0;
    end else if (take_i) begin
      if (wr_o) begin
        cnt_d = 2'd0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + 2'd1;
        acc_d = word_o;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 2'd0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/inst_rom.sv
// Loadable instruction memory: boot loader fills it in LOAD, core fetches in RUN, overflow parks in ERR.
// Optional running checksum of written words when INST_ROM_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int DEPTH_LOG2 = InstMemNumLog2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce_i,
  input  logic [InstAddrBus-1:0] addr_i,
  output logic [InstBus-1:0]     inst_o,
  input  logic                   ld_valid_i,
  input  logic [7:0]             ld_byte_i,
  input  logic                   ld_last_i,
  output logic                   ld_ready_o,
  input  logic                   reload_i,
  output logic                   core_hold_o,
  output logic                   err_o,
  output logic [31:0]            checksum_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [1:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic                  full_q, full_d;
  logic                  hold_q, err_q;
  logic                  asm_clr, asm_wr, mem_we;
  logic [31:0]           asm_word;
  logic [InstBus-1:0]    mem_q [DEPTH];
  logic                  unused_addr_bits;

  assign ld_ready_o  = (state_q == ST_LOAD);
  assign core_hold_o = hold_q;
  assign err_o       = err_q;
  assign unused_addr_bits = ^addr_i[1:0];

  ld_word_asm u_asm (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (asm_clr),
    .take_i (ld_valid_i & ld_ready_o),
    .byte_i (ld_byte_i),
    .last_i (ld_last_i),
    .word_o (asm_word),
    .wr_o   (asm_wr)
  );

  // full_q records that the top word is written, so a further write overflows instead of wrapping.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    full_d  = full_q;
    asm_clr = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (asm_wr) begin
          if (full_q) begin
            state_d = ST_ERR;
          end else begin
            mem_we = 1'b1;
            wptr_d = wptr_q + DEPTH_LOG2'(1);
            if (&wptr_q) full_d = 1'b1;
            if (ld_last_i) state_d = ST_RUN;
          end
        end
      end
      ST_RUN, ST_ERR: begin
        if (reload_i) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
          full_d  = 1'b0;
          asm_clr = 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOAD;
      wptr_q  <= '0;
      full_q  <= 1'b0;
      hold_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      full_q  <= full_d;
      hold_q  <= (state_d != ST_RUN);
      err_q   <= (state_d == ST_ERR);
    end
  end

  // Contents survive reset so a warm reset does not require a reload.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wptr_q] <= asm_word;
  end

  always_comb begin
    inst_o = ZeroWord;
    if (ce_i == ChipEnable && state_q == ST_RUN &&
        addr_i[InstAddrBus-1:DEPTH_LOG2+2] == '0)
      inst_o = mem_q[addr_i[DEPTH_LOG2+1:2]];
  end

`ifdef INST_ROM_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (asm_clr)     checksum_d = '0;
    else if (mem_we) checksum_d = checksum_q + asm_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) checksum_q <= '0;
    else      checksum_q <= checksum_d;
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = ZeroWord;
`endif
endmodule

// File: tb/tb_inst_rom.sv
// Scoreboard bench for inst_rom: loaded words queued as expected, popped on fetch; second small instance for overflow.
`timescale 1ns/1ps
module tb_inst_rom;
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        ce, ld_valid, ld_last, reload, ld_ready, hold, err;
  logic [31:0] addr, inst, csum;
  logic [7:0]  ld_byte;

  logic        ce_s, ld_valid_s, ld_last_s, reload_s, ld_ready_s, hold_s, err_s;
  logic [31:0] addr_s, inst_s, csum_s;
  logic [7:0]  ld_byte_s;

  inst_rom dut (
    .clk(clk), .rst(rst), .ce_i(ce), .addr_i(addr), .inst_o(inst),
    .ld_valid_i(ld_valid), .ld_byte_i(ld_byte), .ld_last_i(ld_last), .ld_ready_o(ld_ready),
    .reload_i(reload), .core_hold_o(hold), .err_o(err), .checksum_o(csum)
  );

  inst_rom #(.DEPTH_LOG2(2)) dut_s (
    .clk(clk), .rst(rst), .ce_i(ce_s), .addr_i(addr_s), .inst_o(inst_s),
    .ld_valid_i(ld_valid_s), .ld_byte_i(ld_byte_s), .ld_last_i(ld_last_s), .ld_ready_o(ld_ready_s),
    .reload_i(reload_s), .core_hold_o(hold_s), .err_o(err_s), .checksum_o(csum_s)
  );

`ifdef INST_ROM_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  logic [31:0] csum_model, csum_model_s;
  logic [31:0] img_s [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  function automatic logic [31:0] exp_csum(input logic [31:0] m);
    return CS_EN ? m : 32'h0;
  endfunction

  // Called at a negedge; the byte is taken at the following posedge.
  task automatic send(input logic [7:0] b, input logic last);
    ld_valid = 1'b1; ld_byte = b; ld_last = last;
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    for (int i = 0; i < 4; i++) send(w[31-8*i -: 8], last && (i == 3));
    exp_q.push_back(w);
    csum_model += w;
  endtask

  task automatic read_back(input int n);
    for (int i = 0; i < n; i++) begin
      ce = 1'b1;
      addr = (i * 4) | $urandom_range(0, 3);
      #1;
      if (exp_q.size() == 0) check("scoreboard_empty", 32'h1, 32'h0);
      else check($sformatf("fetch_w%0d", i), inst, exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    csum_model = 32'h0;
  endtask

  task automatic send_s(input logic [7:0] b, input logic last);
    ld_valid_s = 1'b1; ld_byte_s = b; ld_last_s = last;
    @(negedge clk);
    ld_valid_s = 1'b0; ld_last_s = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0; addr = '0; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0; reload = 1'b0;
    ce_s = 1'b0; addr_s = '0; ld_valid_s = 1'b0; ld_byte_s = '0; ld_last_s = 1'b0; reload_s = 1'b0;
    csum_model = 32'h0; csum_model_s = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_hold", {31'h0, hold}, 32'h1);
    check("rst_err", {31'h0, err}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'h0, ld_ready}, 32'h1);
    check("post_rst_hold", {31'h0, hold}, 32'h1);
    check("post_rst_csum", csum, 32'h0);
    ce = 1'b1; addr = 32'h0; #1;
    check("load_inst_zero", inst, 32'h0);
    @(negedge clk);

    // Two-word image
    send_word(32'h3402_0001, 1'b0);
    send_word(32'h3403_0002, 1'b1);
    check("run_hold_fell", {31'h0, hold}, 32'h0);
    check("run_ready", {31'h0, ld_ready}, 32'h0);
    check("run_csum", csum, exp_csum(csum_model));
    read_back(2);
    ce = 1'b1; addr = 32'h7; #1;
    check("addr_lowbits_ignored", inst, 32'h3403_0002);
    ce = 1'b0; addr = 32'h4; #1;
    check("ce_off_zero", inst, 32'h0);
    ce = 1'b1; addr = 32'h0000_1000; #1;
    check("addr_out_of_range", inst, 32'h0);
    @(negedge clk);
    pulse_reload();
    addr = 32'h4; #1;
    check("reload_hold", {31'h0, hold}, 32'h1);
    check("reload_ready", {31'h0, ld_ready}, 32'h1);
    check("reload_inst_zero", inst, 32'h0);
    check("reload_csum", csum, 32'h0);
    @(negedge clk);

    // Partial final word is zero-padded
    send_word(32'hAABB_CCDD, 1'b0);
    send(8'hEE, 1'b1);
    exp_q.push_back(32'hEE00_0000);
    csum_model += 32'hEE00_0000;
    check("pad_run_hold", {31'h0, hold}, 32'h0);
    check("pad_csum", csum, exp_csum(csum_model));
    read_back(2);

    // Reset mid-load discards partial word; reload_i in LOAD is ignored
    pulse_reload();
    send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b0);
    send(8'h88, 1'b0); send(8'h99, 1'b0); send(8'hAA, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("midload_rst_ready", {31'h0, ld_ready}, 32'h1);
    check("midload_rst_csum", csum, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    csum_model = 32'h0;
    @(negedge clk);
    send(8'h00, 1'b0); send(8'h00, 1'b0);
    reload = 1'b1; @(negedge clk); reload = 1'b0;
    check("reload_in_load_ignored", {31'h0, ld_ready}, 32'h1);
    send(8'h00, 1'b0); send(8'h01, 1'b0);
    exp_q.push_back(32'h0000_0001);
    csum_model += 32'h0000_0001;
    send_word(32'h0000_0002, 1'b1);
    check("img3_csum", csum, exp_csum(32'h3));
    read_back(2);

    // Small instance: exactly full is fine, one byte more overflows
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 4; b++) send_s(8'(8'h10 + w), (w == 3) && (b == 3));
    check("s_full_run_hold", {31'h0, hold_s}, 32'h0);
    check("s_full_err", {31'h0, err_s}, 32'h0);
    reload_s = 1'b1; @(negedge clk); reload_s = 1'b0;
    csum_model_s = 32'h0;
    for (int w = 0; w < 4; w++) begin
      img_s[w] = {4{8'(8'hA0 + w)}};
      csum_model_s += img_s[w];
      for (int b = 0; b < 4; b++) send_s(img_s[w][31-8*b -: 8], 1'b0);
    end
    send_s(8'hFF, 1'b1);
    check("s_ovf_err", {31'h0, err_s}, 32'h1);
    check("s_ovf_ready", {31'h0, ld_ready_s}, 32'h0);
    check("s_ovf_hold", {31'h0, hold_s}, 32'h1);
    check("s_ovf_csum", csum_s, exp_csum(csum_model_s));
    for (int i = 0; i < 4; i++) check($sformatf("s_mem%0d", i), dut_s.mem_q[i], img_s[i]);
    send_s(8'h77, 1'b1);
    ce_s = 1'b1; addr_s = 32'h0; #1;
    check("s_err_sticky", {31'h0, err_s}, 32'h1);
    check("s_err_inst_zero", inst_s, 32'h0);
    @(negedge clk);
    reload_s = 1'b1; @(negedge clk); reload_s = 1'b0;
    check("s_reload_err", {31'h0, err_s}, 32'h0);
    check("s_reload_ready", {31'h0, ld_ready_s}, 32'h1);
    check("s_reload_hold", {31'h0, hold_s}, 32'h1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
